// File: rtl/pipe_motion_ctrl_pkg.sv
// Shared geometry constants, coordinate widths and the pipe FSM state type.
// Used by the spawn, motion, render and collision blocks.
package pipe_motion_ctrl_pkg;

  // Screen and pipe geometry (pixels)
  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned PIPE_WIDTH    = 60;
  localparam int unsigned GAP_HEIGHT    = 120;
  localparam int unsigned GAP_Y_MIN     = 40;
  localparam int unsigned BIRD_X        = 160;

  // Clocks per 1-pixel scroll step
  localparam int unsigned MOVE_SPEED    = 125000;

  // Coordinate widths
  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  typedef enum logic [1:0] {
    s_Idle   = 2'd0,
    s_Moving = 2'd1,
    s_Frozen = 2'd2
  } pipe_state_e;

  // Left edge of a pipe given its exclusive right edge, clipped at x = 0
  function automatic logic [X_W-1:0] clip_left(input logic [X_W-1:0] x_right,
                                                input logic [X_W-1:0] width);
    return (x_right >= width) ? (x_right - width) : '0;
  endfunction

endpackage

// File: rtl/pipe_motion_ctrl_pixel_tick_gen.sv
// Free-running divide-by-PERIOD counter that emits a 1-cycle tick on the
// clock where the count wraps. Holds while disabled; clear forces zero.
module pixel_tick_gen #(
  parameter int unsigned PERIOD = 125000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Enable,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int unsigned   CW   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick is asserted during the last count of each period so the consumer
  // acts on the same edge that wraps the counter back to zero.
  assign o_Tick = i_Enable && !i_Clear && (cnt_q == LAST);

  // Next count: clear wins, otherwise wrap or increment while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (i_Clear) begin
      cnt_d = '0;
    end else if (i_Enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Count register
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_motion_ctrl.sv
// Motion controller for one pipe: spawns just off the right edge on a start
// pulse, latches a random gap, scrolls left one pixel per tick until fully
// off-screen, and pulses once when its right edge passes the bird.
module pipe_motion_ctrl
  import pipe_motion_ctrl_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = pipe_motion_ctrl_pkg::SCREEN_WIDTH,
  parameter int unsigned PIPE_WIDTH   = pipe_motion_ctrl_pkg::PIPE_WIDTH,
  parameter int unsigned MOVE_SPEED   = pipe_motion_ctrl_pkg::MOVE_SPEED,
  parameter int unsigned GAP_Y_MIN    = pipe_motion_ctrl_pkg::GAP_Y_MIN,
  parameter int unsigned GAP_HEIGHT   = pipe_motion_ctrl_pkg::GAP_HEIGHT,
  parameter int unsigned BIRD_X       = pipe_motion_ctrl_pkg::BIRD_X
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  input  logic           i_Start,
  input  logic [7:0]     i_Rand,
  input  logic           i_Freeze,
  output logic           o_Active,
  output logic [X_W-1:0] o_X_Right,
  output logic [X_W-1:0] o_X_Left,
  output logic [Y_W-1:0] o_Gap_Top,
  output logic [Y_W-1:0] o_Gap_Bot,
  output logic           o_Score_Pulse
);

  localparam logic [X_W-1:0] X_START  = X_W'(SCREEN_WIDTH + PIPE_WIDTH);
  localparam logic [X_W-1:0] PIPE_W_X = X_W'(PIPE_WIDTH);
  localparam logic [X_W-1:0] BIRD_X_X = X_W'(BIRD_X);
  localparam logic [Y_W-1:0] GAP_MIN  = Y_W'(GAP_Y_MIN);
  localparam logic [Y_W-1:0] GAP_H    = Y_W'(GAP_HEIGHT);

  pipe_state_e    state_q,   state_d;
  logic           active_q,  active_d;
  logic [X_W-1:0] x_right_q, x_right_d;
  logic [Y_W-1:0] gap_top_q, gap_top_d;
  logic           score_q,   score_d;

  logic step_tick;
  logic tick_enable;
  logic tick_clear;

  // The step counter only runs while scrolling; idle keeps it at zero so
  // the first step lands a full MOVE_SPEED clocks after a spawn.
  assign tick_enable = (state_q == s_Moving) && !i_Freeze;
  assign tick_clear  = (state_q == s_Idle);

  pixel_tick_gen #(
    .PERIOD (MOVE_SPEED)
  ) u_tick (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Enable (tick_enable),
    .i_Clear  (tick_clear),
    .o_Tick   (step_tick)
  );

  // Next-state logic: spawn, scroll, end-of-travel, score and freeze
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    x_right_d = x_right_q;
    gap_top_d = gap_top_q;
    score_d   = 1'b0;
    unique case (state_q)
      s_Idle: begin
        if (i_Start && !i_Freeze) begin
          state_d   = s_Moving;
          active_d  = 1'b1;
          x_right_d = X_START;
          gap_top_d = GAP_MIN + Y_W'(i_Rand);
        end
      end
      s_Moving: begin
        // Freeze takes priority and swallows any step due this cycle
        if (i_Freeze) begin
          state_d = s_Frozen;
        end else if (step_tick) begin
          x_right_d = x_right_q - X_W'(1);
          // Right edge moving from BIRD_X to BIRD_X-1 is the single crossing
          if (x_right_q == BIRD_X_X) begin
            score_d = 1'b1;
          end
          if (x_right_q == X_W'(1)) begin
            state_d  = s_Idle;
            active_d = 1'b0;
          end
        end
      end
      s_Frozen: begin
        // Game over: hold everything until reset
      end
      default: begin
        state_d  = s_Idle;
        active_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= s_Idle;
      active_q  <= 1'b0;
      x_right_q <= '0;
      gap_top_q <= '0;
      score_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      x_right_q <= x_right_d;
      gap_top_q <= gap_top_d;
      score_q   <= score_d;
    end
  end

  assign o_Active      = active_q;
  assign o_X_Right     = x_right_q;
  assign o_X_Left      = clip_left(x_right_q, PIPE_W_X);
  assign o_Gap_Top     = gap_top_q;
  assign o_Gap_Bot     = gap_top_q + GAP_H;
  assign o_Score_Pulse = score_q;

endmodule

// File: tb/tb_pipe_motion_ctrl.sv
// Directed bench for pipe_motion_ctrl with a small screen so full runs are short.
module tb_pipe_motion_ctrl;

  localparam int SW = 20;
  localparam int PW = 5;
  localparam int MS = 4;
  localparam int BX = 8;
  localparam int GMIN = 40;
  localparam int GH = 120;
  localparam int RUN_CYCLES = (SW + PW) * MS;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rand_val;
  logic        freeze;
  logic        active;
  logic [10:0] x_right;
  logic [10:0] x_left;
  logic [9:0]  gap_top;
  logic [9:0]  gap_bot;
  logic        score_pulse;

  int tests_run    = 0;
  int tests_failed = 0;

  // Monitor tallies
  int act_cnt   = 0;
  int pulse_cnt = 0;
  int pulse_x   = -1;
  int clip_err  = 0;

  pipe_motion_ctrl #(
    .SCREEN_WIDTH (SW),
    .PIPE_WIDTH   (PW),
    .MOVE_SPEED   (MS),
    .GAP_Y_MIN    (GMIN),
    .GAP_HEIGHT   (GH),
    .BIRD_X       (BX)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Start       (start),
    .i_Rand        (rand_val),
    .i_Freeze      (freeze),
    .o_Active      (active),
    .o_X_Right     (x_right),
    .o_X_Left      (x_left),
    .o_Gap_Top     (gap_top),
    .o_Gap_Bot     (gap_bot),
    .o_Score_Pulse (score_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle tallies, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (active) act_cnt++;
    if (score_pulse) begin
      pulse_cnt++;
      pulse_x = int'(x_right);
    end
    if (active && (int'(x_left) != ((int'(x_right) >= PW) ? int'(x_right) - PW : 0)))
      clip_err++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " active"},  int'(active),      0);
    chk({tag, " x_right"}, int'(x_right),     0);
    chk({tag, " x_left"},  int'(x_left),      0);
    chk({tag, " gap_top"}, int'(gap_top),     0);
    chk({tag, " gap_bot"}, int'(gap_bot),     GH);
    chk({tag, " score"},   int'(score_pulse), 0);
  endtask

  // Call at a negedge; returns at the following negedge (one edge after accept)
  task automatic do_start(input logic [7:0] r);
    rand_val = r;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_xr(input int target, input string tag);
    int n = 0;
    while (int'(x_right) != target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(x_right), target);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (active && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(active), 0);
  endtask

  initial begin
    int a0, p0, hold_err;
    rst = 1'b1; start = 1'b0; rand_val = 8'h00; freeze = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Spawn geometry and first-step latency
    a0 = act_cnt; p0 = pulse_cnt;
    do_start(8'h10);
    chk("spawn active",  int'(active),  1);
    chk("spawn x_right", int'(x_right), 25);
    chk("spawn x_left",  int'(x_left),  20);
    chk("spawn gap_top", int'(gap_top), 56);
    chk("spawn gap_bot", int'(gap_bot), 176);
    repeat (3) @(negedge clk);
    chk("no step at 3 clocks", int'(x_right), 25);
    @(negedge clk);
    chk("step at 4 clocks", int'(x_right), 24);

    // Full run: duration, clipping, single score pulse at x_right 7
    wait_idle("run1 ends");
    @(negedge clk);
    chk("run1 active cycles", act_cnt - a0, RUN_CYCLES);
    chk("run1 score pulses",  pulse_cnt - p0, 1);
    chk("run1 pulse x_right", pulse_x, BX - 1);
    chk("run1 final x_right", int'(x_right), 0);
    chk("run1 final x_left",  int'(x_left), 0);
    chk("run1 clip errors",   clip_err, 0);

    // Start while frozen in idle is ignored
    freeze = 1'b1;
    do_start(8'h33);
    @(negedge clk);
    chk("idle start+freeze ignored", int'(active), 0);
    freeze = 1'b0;

    // Second run scores exactly once more
    a0 = act_cnt; p0 = pulse_cnt;
    do_start(8'h00);
    chk("run2 gap_top", int'(gap_top), 40);
    chk("run2 gap_bot", int'(gap_bot), 160);
    wait_idle("run2 ends");
    @(negedge clk);
    chk("run2 active cycles", act_cnt - a0, RUN_CYCLES);
    chk("run2 score pulses",  pulse_cnt - p0, 1);

    // Freeze at x_right 15, on the cycle a step is due
    do_start(8'hFF);
    chk("run3 gap_top", int'(gap_top), 295);
    chk("run3 gap_bot", int'(gap_bot), 415);
    wait_xr(15, "reach x_right 15");
    repeat (3) @(negedge clk);
    freeze = 1'b1;
    p0 = pulse_cnt;
    hold_err = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 10) do_start(8'h77);
      else @(negedge clk);
      if (x_right != 11'd15 || gap_top != 10'd295 || !active) hold_err++;
    end
    chk("freeze hold errors", hold_err, 0);
    chk("freeze x_right",     int'(x_right), 15);
    chk("freeze active",      int'(active), 1);
    chk("freeze no score",    pulse_cnt - p0, 0);

    // Only reset leaves the frozen state
    rst = 1'b1;
    #2;
    chk_reset_vals("reset from frozen");
    @(negedge clk);
    rst = 1'b0; freeze = 1'b0;
    @(negedge clk);

    // Extra start while moving is ignored
    a0 = act_cnt; p0 = pulse_cnt;
    do_start(8'h20);
    wait_xr(12, "reach x_right 12");
    do_start(8'h55);
    chk("restart x_right", int'(x_right), 12);
    chk("restart gap_top", int'(gap_top), 72);
    wait_idle("run4 ends");
    @(negedge clk);
    chk("run4 active cycles", act_cnt - a0, RUN_CYCLES);
    chk("run4 score pulses",  pulse_cnt - p0, 1);

    // Async reset mid-run, between clock edges
    p0 = pulse_cnt;
    do_start(8'h01);
    wait_xr(10, "reach x_right 10");
    rst = 1'b1;
    #1;
    chk_reset_vals("mid-run reset");
    @(negedge clk);
    chk("mid-run reset no score", pulse_cnt - p0, 0);
    rst = 1'b0;
    @(negedge clk);
    do_start(8'h02);
    chk("after reset x_right", int'(x_right), 25);
    chk("after reset gap_top", int'(gap_top), 42);
    chk("after reset active",  int'(active), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
